// File: rtl/tx_packet_framer.sv
// -----------------------------------------------------------------------------
// tx_packet_framer
//
// Transmit-side framer between the SPI slave byte stream and the RF modulator.
// Payload bytes are collected into an internal buffer over a valid/ready
// interface. Once the buffer is full, a level-sampled `start` launches one
// on-air frame, serialised MSB first at one bit per BIT_DIV clocks:
//    PREAMBLE_BYTES x 0xAA | SYNC_WORD | payload[0..N-1] | CRC-8 (poly 0x07)
// The CRC is accumulated serially over the payload bits as they leave the
// line, so the frame loops back cleanly through the RX shift buffer.
//
// Ports
//    clk        in   system clock
//    rst        in   asynchronous, active-high reset
//    din[7:0]   in   payload byte
//    din_valid  in   din is valid this cycle
//    din_ready  out  buffer can accept a byte (idle and not yet full)
//    start      in   request transmission (accepted only with a full buffer)
//    abort      in   synchronous cancel of the frame or of the loading
//    busy       out  frame in progress
//    done       out  one-cycle pulse after the last CRC bit
//    tx_out     out  serial data to the modulator (registered)
//    tx_en      out  PA enable, high for the whole frame (registered)
// -----------------------------------------------------------------------------
module tx_packet_framer #(
   parameter int         PAYLOAD_BYTES  = 8,
   parameter int         PREAMBLE_BYTES = 2,
   parameter logic [7:0] SYNC_WORD      = 8'hD3,
   parameter int         BIT_DIV        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       start,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       tx_out,
   output logic       tx_en
);

   localparam int               DIV_W         = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(BIT_DIV - 1);
   localparam logic [3:0]       FULL          = 4'(PAYLOAD_BYTES);
   localparam logic [3:0]       PAY_LAST      = 4'(PAYLOAD_BYTES - 1);
   localparam logic [3:0]       PRE_LAST      = 4'(PREAMBLE_BYTES - 1);
   localparam logic [7:0]       PREAMBLE_BYTE = 8'hAA;
   localparam logic [7:0]       CRC_POLY      = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_PAYLOAD,
      ST_CRC
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       count_q, count_d;   // bytes held in the buffer
   logic [DIV_W-1:0] div_q,   div_d;     // clocks into the current bit
   logic [2:0]       bit_q,   bit_d;     // bit within the current byte, 0 = MSB
   logic [3:0]       byte_q,  byte_d;    // byte within the current field
   logic [7:0]       crc_q,   crc_d;
   logic             tx_out_q, tx_out_d;
   logic             tx_en_q,  tx_en_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             wr_en;
   logic [7:0]       line_byte;
   logic [7:0]       buf_q [PAYLOAD_BYTES];

   assign din_ready = (state_q == ST_IDLE) && (count_q < FULL);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      count_d = count_q;
      div_d   = div_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      crc_d   = crc_q;
      tx_en_d = tx_en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;

      if (abort) begin
         // Abort wins over start and over a same-cycle write; no done pulse.
         state_d = ST_IDLE;
         count_d = 4'd0;
         tx_en_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (din_valid && din_ready) begin
                  wr_en   = 1'b1;
                  count_d = count_q + 4'd1;
               end
               // Uses the pre-edge count, so a filling write and start on the
               // same edge do not launch a frame.
               if (start && (count_q == FULL)) begin
                  state_d = ST_PREAMBLE;
                  div_d   = '0;
                  bit_d   = 3'd0;
                  byte_d  = 4'd0;
                  crc_d   = 8'h00;
               end
            end

            default: begin
               if (!tx_en_q) begin
                  // First cycle after acceptance: the line is still quiet and
                  // the counters hold, so bit 0 appears one edge later.
                  tx_en_d = 1'b1;
                  busy_d  = 1'b1;
               end else if (div_q == DIV_LAST) begin
                  div_d = '0;
                  if (state_q == ST_PAYLOAD) begin
                     // Fold the payload bit that just finished on the line.
                     crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ tx_out_q) ? CRC_POLY : 8'h00);
                  end
                  if (bit_q != 3'd7) begin
                     bit_d = bit_q + 3'd1;
                  end else begin
                     bit_d  = 3'd0;
                     byte_d = byte_q + 4'd1;
                     case (state_q)
                        ST_PREAMBLE: begin
                           if (byte_q == PRE_LAST) begin
                              state_d = ST_SYNC;
                              byte_d  = 4'd0;
                           end
                        end
                        ST_SYNC: begin
                           state_d = ST_PAYLOAD;
                           byte_d  = 4'd0;
                        end
                        ST_PAYLOAD: begin
                           if (byte_q == PAY_LAST) begin
                              state_d = ST_CRC;
                              byte_d  = 4'd0;
                           end
                        end
                        default: begin
                           // Last CRC bit done: drop the line and free the buffer.
                           state_d = ST_IDLE;
                           byte_d  = 4'd0;
                           count_d = 4'd0;
                           tx_en_d = 1'b0;
                           busy_d  = 1'b0;
                           done_d  = 1'b1;
                        end
                     endcase
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Line data: the bit addressed by the next-state counters, registered so
   // tx_out has no combinational path from the inputs.
   // -------------------------------------------------------------------------
   always_comb begin
      line_byte = 8'h00;
      case (state_d)
         ST_PREAMBLE: line_byte = PREAMBLE_BYTE;
         ST_SYNC:     line_byte = SYNC_WORD;
         ST_PAYLOAD: begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
               if (byte_d == 4'(i)) line_byte = buf_q[i];
            end
         end
         ST_CRC:      line_byte = crc_d;
         default:     line_byte = 8'h00;
      endcase
      tx_out_d = tx_en_d & line_byte[3'd7 - bit_d];
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments make every flop sample pre-edge values,
   // independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= 4'd0;
         div_q    <= '0;
         bit_q    <= 3'd0;
         byte_q   <= 4'd0;
         crc_q    <= 8'h00;
         tx_out_q <= 1'b0;
         tx_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         crc_q    <= crc_d;
         tx_out_q <= tx_out_d;
         tx_en_q  <= tx_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // NOTE: the payload buffer has no reset; count gates every read, so stale
   // contents are never transmitted and the array maps onto plain storage.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         if (wr_en && (count_q == 4'(i))) buf_q[i] <= din;
      end
   end

   assign tx_out = tx_out_q;
   assign tx_en  = tx_en_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_packet_framer
//
// Three framer instances share one clock and reset:
//    u0: defaults (8 payload bytes, 16 clocks/bit)
//    u1: 9 payload bytes, 2 clocks/bit (minimum divider)
//    u2: 1 payload byte, 3 clocks/bit (odd divider)
// Expected line streams are built from bytes (preamble, sync, payload, CRC)
// with a byte-wise CRC-8 reference and checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_tx_packet_framer;

   localparam int NI  = 3;
   localparam int PRE = 2;
   localparam int PB [NI] = '{8, 9, 1};
   localparam int BD [NI] = '{16, 2, 3};

   logic                clk = 1'b0;
   logic                rst;
   logic [NI-1:0][7:0]  din;
   logic [NI-1:0]       din_valid;
   logic [NI-1:0]       start;
   logic [NI-1:0]       abort;
   wire  [NI-1:0]       din_ready;
   wire  [NI-1:0]       busy;
   wire  [NI-1:0]       done;
   wire  [NI-1:0]       tx_out;
   wire  [NI-1:0]       tx_en;

   int           n_cmp = 0;
   int           n_bad = 0;
   byte unsigned pay_q [$];
   bit           exp_q [$];
   bit           got_q [$];
   byte unsigned exp_crc;

   typedef struct {
      int           inst;
      int           len;
      byte unsigned data [16];
      bit           use_model;
      byte unsigned crc;
   } vec_t;

   vec_t vecs [3];

   always #5 clk = ~clk;

   tx_packet_framer #(.PAYLOAD_BYTES(PB[0]), .BIT_DIV(BD[0])) u0 (
      .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
      .start(start[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]),
      .tx_out(tx_out[0]), .tx_en(tx_en[0]));

   tx_packet_framer #(.PAYLOAD_BYTES(PB[1]), .BIT_DIV(BD[1])) u1 (
      .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
      .start(start[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]),
      .tx_out(tx_out[1]), .tx_en(tx_en[1]));

   tx_packet_framer #(.PAYLOAD_BYTES(PB[2]), .BIT_DIV(BD[2])) u2 (
      .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
      .start(start[2]), .abort(abort[2]), .busy(busy[2]), .done(done[2]),
      .tx_out(tx_out[2]), .tx_en(tx_en[2]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Byte-wise CRC-8, poly 0x07, init 0, no reflection, no final XOR.
   function automatic byte unsigned crc8_ref(input byte unsigned d [$]);
      byte unsigned c = 8'h00;
      foreach (d[i]) begin
         c = c ^ d[i];
         for (int b = 0; b < 8; b++) c = (c << 1) ^ (c[7] ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   function automatic void make_frame(input byte unsigned d [$], input byte unsigned crc);
      byte unsigned bytes [$];
      exp_q.delete();
      for (int i = 0; i < PRE; i++) bytes.push_back(8'hAA);
      bytes.push_back(8'hD3);
      foreach (d[i]) bytes.push_back(d[i]);
      bytes.push_back(crc);
      foreach (bytes[i]) for (int b = 7; b >= 0; b--) exp_q.push_back(bytes[i][b]);
      exp_crc = crc;
   endfunction

   task automatic rand_payload(input int n);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
   endtask

   // Writes pay_q[0..n-1]; din_ready must be high before every write.
   task automatic load(input int k, input int n, input bit exp_full, input string name);
      int errs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (din_ready[k] !== 1'b1) errs++;
         din[k]       = pay_q[i];
         din_valid[k] = 1'b1;
      end
      @(negedge clk);
      din_valid[k] = 1'b0;
      check({name, ":load_not_ready"}, errs, 0);
      check({name, ":ready_after_load"}, din_ready[k], exp_full ? 1'b0 : 1'b1);
   endtask

   // Pulses start and checks every cycle of the frame against exp_q.
   // cut_kind: 0 full frame, 1 abort at cycle cut_at, 2 reset at cycle cut_at.
   task automatic frame(input int k, input string name, input bit poke, input bit hold_start,
                        input int cut_at, input int cut_kind);
      int   d    = BD[k];
      int   f    = exp_q.size();
      int   errs = 0;
      int   last;
      bit   eb;
      logic [7:0] gc;
      got_q.delete();
      @(negedge clk);
      start[k] = 1'b1;
      @(negedge clk);
      if (!hold_start) start[k] = 1'b0;
      check({name, ":quiet_after_accept"}, {tx_en[k], busy[k], din_ready[k]}, 3'b000);
      last = (cut_kind != 0) ? cut_at : f * d;
      for (int c = 1; c <= last; c++) begin
         if (poke) begin
            din_valid[k] = 1'b1;
            din[k]       = 8'($urandom);
         end
         @(negedge clk);
         eb = exp_q[(c - 1) / d];
         if (tx_en[k] !== 1'b1 || busy[k] !== 1'b1 || done[k] !== 1'b0 ||
             din_ready[k] !== 1'b0 || tx_out[k] !== eb) begin
            if (errs == 0)
               $display("  %s first bad cycle %0d: tx_out=%b tx_en=%b busy=%b done=%b ready=%b, want tx_out=%b 1 1 0 0",
                        name, c, tx_out[k], tx_en[k], busy[k], done[k], din_ready[k], eb);
            errs++;
         end
         if (c % d == 0) got_q.push_back(tx_out[k]);
      end
      din_valid[k] = 1'b0;
      check({name, ":frame_cycle_errors"}, errs, 0);

      if (cut_kind == 0) begin
         gc = 8'h00;
         for (int b = 0; b < 8; b++) gc = {gc[6:0], got_q[f - 8 + b]};
         check({name, ":crc_byte"}, gc, exp_crc);
         @(negedge clk);
         check({name, ":done_cycle en,busy,done,rdy,out"},
               {tx_en[k], busy[k], done[k], din_ready[k], tx_out[k]}, 5'b00110);
         @(negedge clk);
         check({name, ":done_one_cycle"}, done[k], 1'b0);
         if (hold_start) begin
            errs = 0;
            for (int c = 0; c < 3 * d; c++) begin
               @(negedge clk);
               if (tx_en[k] !== 1'b0 || busy[k] !== 1'b0) errs++;
            end
            start[k] = 1'b0;
            check({name, ":no_retransmit_when_empty"}, errs, 0);
         end
      end else if (cut_kind == 1) begin
         abort[k] = 1'b1;
         @(negedge clk);
         abort[k] = 1'b0;
         check({name, ":after_abort en,busy,done,rdy,out"},
               {tx_en[k], busy[k], done[k], din_ready[k], tx_out[k]}, 5'b00010);
         errs = 0;
         for (int c = 0; c < 2 * d; c++) begin
            @(negedge clk);
            if (done[k] !== 1'b0 || tx_en[k] !== 1'b0) errs++;
         end
         check({name, ":no_done_after_abort"}, errs, 0);
      end else begin
         #2 rst = 1'b1;
         #1;
         check({name, ":async_reset en,busy,done,rdy,out"},
               {tx_en[k], busy[k], done[k], din_ready[k], tx_out[k]}, 5'b00010);
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         check({name, ":ready_after_reset"}, din_ready[k], 1'b1);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs;
      int k;

      din       = '0;
      din_valid = '0;
      start     = '0;
      abort     = '0;
      rst       = 1'b1;

      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 16; i++) vecs[v].data[i] = 8'h00;
         vecs[v].use_model = 1'b0;
         vecs[v].crc       = 8'h00;
      end
      vecs[0].inst = 0; vecs[0].len = 8; vecs[0].use_model = 1'b1;
      for (int i = 0; i < 8; i++) vecs[0].data[i] = 8'(i);
      vecs[1].inst = 1; vecs[1].len = 9; vecs[1].crc = 8'hF4;
      for (int i = 0; i < 9; i++) vecs[1].data[i] = 8'(8'h31 + i);
      vecs[2].inst = 2; vecs[2].len = 1; vecs[2].crc = 8'h07;
      vecs[2].data[0] = 8'h01;

      // Reset values on every instance.
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++)
         check($sformatf("reset%0d out,en,busy,done,rdy", i),
               {tx_out[i], tx_en[i], busy[i], done[i], din_ready[i]}, 5'b00001);
      rst = 1'b0;

      // Known vectors: 00..07 (model CRC), "123456789" -> F4, 01 -> 07.
      for (int v = 0; v < 3; v++) begin
         pay_q.delete();
         for (int i = 0; i < vecs[v].len; i++) pay_q.push_back(vecs[v].data[i]);
         make_frame(pay_q, vecs[v].use_model ? crc8_ref(pay_q) : vecs[v].crc);
         load(vecs[v].inst, vecs[v].len, 1'b1, $sformatf("vec%0d", v));
         frame(vecs[v].inst, $sformatf("vec%0d", v), 1'b0, 1'b0, 0, 0);
      end

      // start with 7 of 8 bytes, then the filling write with start on the same edge.
      rand_payload(8);
      load(0, 7, 1'b0, "part7");
      start[0] = 1'b1;
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_en[0] !== 1'b0 || busy[0] !== 1'b0) errs++;
      end
      check("part7:idle_with_start", errs, 0);
      din[0]       = pay_q[7];
      din_valid[0] = 1'b1;
      @(negedge clk);
      din_valid[0] = 1'b0;
      start[0]     = 1'b0;
      check("fill_start:tx_en", tx_en[0], 1'b0);
      check("fill_start:ready_full", din_ready[0], 1'b0);
      @(negedge clk);
      check("fill_start:still_idle", {tx_en[0], busy[0]}, 2'b00);
      make_frame(pay_q, crc8_ref(pay_q));
      frame(0, "after_fill", 1'b0, 1'b0, 0, 0);

      // Writes during the frame are dropped; a refill with the same data
      // must produce the identical frame.
      rand_payload(8);
      make_frame(pay_q, crc8_ref(pay_q));
      load(0, 8, 1'b1, "poke");
      frame(0, "poke", 1'b1, 1'b0, 0, 0);
      load(0, 8, 1'b1, "refill");
      frame(0, "retx", 1'b0, 1'b0, 0, 0);

      // Abort inside payload byte 3 (frame bit 50), then count must be 0.
      rand_payload(8);
      make_frame(pay_q, crc8_ref(pay_q));
      load(0, 8, 1'b1, "abort");
      frame(0, "abort", 1'b0, 1'b0, 50 * BD[0] + 1, 1);
      rand_payload(8);
      make_frame(pay_q, crc8_ref(pay_q));
      load(0, 8, 1'b1, "post_abort");
      frame(0, "post_abort", 1'b0, 1'b0, 0, 0);

      // Asynchronous reset at frame bit 40, then count must be 0.
      rand_payload(8);
      make_frame(pay_q, crc8_ref(pay_q));
      load(0, 8, 1'b1, "rst40");
      frame(0, "rst40", 1'b0, 1'b0, 40 * BD[0] + 1, 2);
      load(0, 8, 1'b1, "post_rst");

      // start held high through and after the frame.
      rand_payload(1);
      make_frame(pay_q, crc8_ref(pay_q));
      load(2, 1, 1'b1, "hold");
      frame(2, "hold", 1'b0, 1'b1, 0, 0);

      // Random payloads on the short-frame instances.
      for (int r = 0; r < 6; r++) begin
         k = 1 + (r % 2);
         rand_payload(PB[k]);
         make_frame(pay_q, crc8_ref(pay_q));
         load(k, PB[k], 1'b1, $sformatf("rnd%0d", r));
         frame(k, $sformatf("rnd%0d", r), 1'b0, 1'b0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
